// File: rtl/caliptra_esc_phase_ctrl.sv
// Escalation phase sequencer: starts on an accumulated-alert trigger or after
// an interrupt-timeout countdown, walks four programmable-length phases, then
// parks in a sticky Terminal state. Per-signal requests into the escalation
// senders follow a phase map. An illegal state encoding forces Terminal, sets
// a sticky error flag and asserts every escalation request.

package caliptra_esc_phase_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StTimeout  = 3'd1,
    StTerminal = 3'd3,
    StPhase0   = 3'd4,
    StPhase1   = 3'd5,
    StPhase2   = 3'd6,
    StPhase3   = 3'd7
  } state_e;

endpackage

module caliptra_esc_phase_ctrl
  import caliptra_esc_phase_ctrl_pkg::*;
#(
  parameter int unsigned NumSignals = 4,
  parameter int unsigned CntW       = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic                    clr_lock_i,
  input  logic                    accum_trig_i,
  input  logic                    timeout_en_i,
  input  logic [CntW-1:0]         timeout_cyc_i,
  input  logic [4*CntW-1:0]       phase_cyc_i,
  input  logic [2*NumSignals-1:0] esc_map_i,
  input  logic [NumSignals-1:0]   esc_en_i,
  output logic [NumSignals-1:0]   esc_sig_req_o,
  output logic                    esc_trig_o,
  output logic [CntW-1:0]         esc_cnt_o,
  output logic [2:0]              esc_state_o,
  output logic                    esc_fsm_err_o
);

  state_e                state_q, state_d, state_raw_s, next_phase_s;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [CntW-1:0]       phase_dur_s;
  logic [NumSignals-1:0] req_q, req_d;
  logic                  trig_q, trig_d;
  logic                  err_q, err_d;
  logic                  illegal_s;
  logic                  clr_ok_s;
  logic                  cnt_run_s;
  logic [2:0]            state_d_bits_s;

  // A clear is honoured in phases and Terminal only when not locked.
  assign clr_ok_s = clr_i & ~clr_lock_i;

  // Select the duration and successor of the phase currently active.
  always_comb begin
    phase_dur_s  = {CntW{1'b0}};
    next_phase_s = StTerminal;
    case (state_q)
      StPhase0: begin
        phase_dur_s  = phase_cyc_i[CntW-1:0];
        next_phase_s = StPhase1;
      end
      StPhase1: begin
        phase_dur_s  = phase_cyc_i[2*CntW-1:CntW];
        next_phase_s = StPhase2;
      end
      StPhase2: begin
        phase_dur_s  = phase_cyc_i[3*CntW-1:2*CntW];
        next_phase_s = StPhase3;
      end
      StPhase3: begin
        phase_dur_s  = phase_cyc_i[4*CntW-1:3*CntW];
        next_phase_s = StTerminal;
      end
      default: begin
        phase_dur_s  = {CntW{1'b0}};
        next_phase_s = StTerminal;
      end
    endcase
  end

  // Next-state decision; any unused encoding is treated as a fault.
  always_comb begin
    state_raw_s = state_q;
    illegal_s   = 1'b0;
    case (state_q)
      StIdle: begin
        if (en_i && accum_trig_i) begin
          state_raw_s = StPhase0;
        end else if (en_i && timeout_en_i) begin
          state_raw_s = StTimeout;
        end else begin
          state_raw_s = StIdle;
        end
      end
      StTimeout: begin
        if (accum_trig_i || (cnt_q >= timeout_cyc_i)) begin
          state_raw_s = StPhase0;
        end else if (clr_i || !en_i || !timeout_en_i) begin
          state_raw_s = StIdle;
        end else begin
          state_raw_s = StTimeout;
        end
      end
      StPhase0, StPhase1, StPhase2, StPhase3: begin
        if (clr_ok_s) begin
          state_raw_s = StIdle;
        end else if (cnt_q >= phase_dur_s) begin
          state_raw_s = next_phase_s;
        end else begin
          state_raw_s = state_q;
        end
      end
      StTerminal: begin
        if (clr_ok_s) begin
          state_raw_s = StIdle;
        end else begin
          state_raw_s = StTerminal;
        end
      end
      default: begin
        illegal_s   = 1'b1;
        state_raw_s = StTerminal;
      end
    endcase
  end

  // Once a fault has been seen the FSM is pinned in Terminal until reset.
  always_comb begin
    err_d          = err_q | illegal_s;
    state_d        = (err_q || illegal_s) ? StTerminal : state_raw_s;
    state_d_bits_s = state_d;
  end

  // Cycle counter: cleared on any state change, saturating count otherwise.
  always_comb begin
    cnt_run_s = (state_q == StTimeout) || (state_q == StPhase0) ||
                (state_q == StPhase1)  || (state_q == StPhase2)  ||
                (state_q == StPhase3);
    if (state_d != state_q) begin
      cnt_d = {CntW{1'b0}};
    end else if (cnt_run_s && (cnt_q != {CntW{1'b1}})) begin
      cnt_d = cnt_q + {{(CntW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Requests and trigger pulse are derived from the next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    req_d = {NumSignals{1'b0}};
    for (int i = 0; i < NumSignals; i++) begin
      req_d[i] = err_d |
                 (esc_en_i[i] & (state_d_bits_s == {1'b1, esc_map_i[2*i +: 2]}));
    end
    trig_d = (state_d == StPhase0) && (state_q != StPhase0);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= {CntW{1'b0}};
      req_q   <= {NumSignals{1'b0}};
      trig_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      trig_q  <= trig_d;
      err_q   <= err_d;
    end
  end

  assign esc_sig_req_o = req_q;
  assign esc_trig_o    = trig_q;
  assign esc_cnt_o     = cnt_q;
  assign esc_state_o   = state_q;
  assign esc_fsm_err_o = err_q;

endmodule

// File: tb/tb_caliptra_esc_phase_ctrl.sv
// Directed bench for caliptra_esc_phase_ctrl: expected outputs are queued as
// each step's stimulus is applied and compared one cycle later.

module tb_caliptra_esc_phase_ctrl;

  logic         clk;
  logic         rst_n;
  logic         en, clr, clr_lock, accum, tmo_en;
  logic [31:0]  tmo_cyc;
  logic [127:0] phase_cyc;
  logic [7:0]   esc_map;
  logic [3:0]   esc_en;
  logic [3:0]   req;
  logic         trig;
  logic [31:0]  cnt;
  logic [2:0]   st;
  logic         err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [3:0]  req;
    logic        trig;
    logic [31:0] cnt;
    logic        err;
  } exp_t;

  exp_t sb[$];

  caliptra_esc_phase_ctrl #(.NumSignals(4), .CntW(32)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .en_i          (en),
    .clr_i         (clr),
    .clr_lock_i    (clr_lock),
    .accum_trig_i  (accum),
    .timeout_en_i  (tmo_en),
    .timeout_cyc_i (tmo_cyc),
    .phase_cyc_i   (phase_cyc),
    .esc_map_i     (esc_map),
    .esc_en_i      (esc_en),
    .esc_sig_req_o (req),
    .esc_trig_o    (trig),
    .esc_cnt_o     (cnt),
    .esc_state_o   (st),
    .esc_fsm_err_o (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [2:0] s, input logic [3:0] r,
                      input logic t, input logic [31:0] c, input logic e);
    exp_t x;
    x.tag = tag; x.st = s; x.req = r; x.trig = t; x.cnt = c; x.err = e;
    sb.push_back(x);
  endtask

  task automatic cmp1(input string tag, input string fld,
                      input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, expv);
    end
  endtask

  task automatic pop_cmp();
    exp_t x;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      x = sb.pop_front();
      cmp1(x.tag, "state", {29'd0, st},   {29'd0, x.st});
      cmp1(x.tag, "req",   {28'd0, req},  {28'd0, x.req});
      cmp1(x.tag, "trig",  {31'd0, trig}, {31'd0, x.trig});
      cmp1(x.tag, "cnt",   cnt,           x.cnt);
      cmp1(x.tag, "err",   {31'd0, err},  {31'd0, x.err});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pop_cmp();
  endtask

  // Full walk with phase_cyc={3,2,1,0}, identity map, all signals enabled.
  task automatic walk(input string tag);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c <= k; c++) begin
        push(tag, 3'(4 + k), 4'(1 << k), 1'((k == 0) && (c == 0)), 32'(c), 1'b0);
        step();
        accum = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    clr       = 1'b0;
    clr_lock  = 1'b0;
    accum     = 1'b0;
    tmo_en    = 1'b0;
    tmo_cyc   = 32'd5;
    phase_cyc = {32'd3, 32'd2, 32'd1, 32'd0};
    esc_map   = 8'b11_10_01_00;
    esc_en    = 4'hF;
    #12;
    push("reset", 3'd0, 4'h0, 1'b0, 32'd0, 1'b0);
    pop_cmp();
    rst_n = 1'b1;

    // Trigger without class enable is ignored.
    accum = 1'b1;
    push("en_gate", 3'd0, 4'h0, 1'b0, 32'd0, 1'b0);
    step();

    // Trigger path through all phases into Terminal.
    en = 1'b1;
    walk("trig_path");
    push("terminal", 3'd3, 4'h0, 1'b0, 32'd0, 1'b0);
    step();
    push("terminal_hold", 3'd3, 4'h0, 1'b0, 32'd0, 1'b0);
    step();
    clr = 1'b1;
    push("term_clr", 3'd0, 4'h0, 1'b0, 32'd0, 1'b0);
    step();
    clr = 1'b0;

    // Timeout countdown of 5 cycles.
    tmo_cyc = 32'd5;
    tmo_en  = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      push("timeout", 3'd1, 4'h0, 1'b0, 32'(c), 1'b0);
      step();
    end
    push("timeout_expire", 3'd4, 4'h1, 1'b1, 32'd0, 1'b0);
    step();
    tmo_en = 1'b0;
    clr    = 1'b1;
    push("p0_clr", 3'd0, 4'h0, 1'b0, 32'd0, 1'b0);
    step();
    clr = 1'b0;

    // Timeout aborted by dropping the interrupt at cnt=3.
    tmo_en = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      push("tmo_abort", 3'd1, 4'h0, 1'b0, 32'(c), 1'b0);
      step();
    end
    tmo_en = 1'b0;
    push("tmo_drop", 3'd0, 4'h0, 1'b0, 32'd0, 1'b0);
    step();
    push("tmo_drop_idle", 3'd0, 4'h0, 1'b0, 32'd0, 1'b0);
    step();

    // Zero timeout: Phase0 one cycle after entering Timeout.
    tmo_cyc = 32'd0;
    tmo_en  = 1'b1;
    push("tmo_zero", 3'd1, 4'h0, 1'b0, 32'd0, 1'b0);
    step();
    push("tmo_zero_p0", 3'd4, 4'h1, 1'b1, 32'd0, 1'b0);
    step();
    tmo_en = 1'b0;
    clr    = 1'b1;
    push("tmo_zero_clr", 3'd0, 4'h0, 1'b0, 32'd0, 1'b0);
    step();
    clr = 1'b0;

    // Unlocked clear in Phase1.
    accum = 1'b1;
    push("clr_p0", 3'd4, 4'h1, 1'b1, 32'd0, 1'b0);
    step();
    accum = 1'b0;
    push("clr_p1", 3'd5, 4'h2, 1'b0, 32'd0, 1'b0);
    step();
    clr = 1'b1;
    push("clr_p1_idle", 3'd0, 4'h0, 1'b0, 32'd0, 1'b0);
    step();
    clr = 1'b0;

    // Locked clear is ignored through phases and Terminal.
    clr      = 1'b1;
    clr_lock = 1'b1;
    accum    = 1'b1;
    walk("lock_walk");
    push("lock_term", 3'd3, 4'h0, 1'b0, 32'd0, 1'b0);
    step();
    push("lock_term_hold", 3'd3, 4'h0, 1'b0, 32'd0, 1'b0);
    step();
    clr_lock = 1'b0;
    push("unlock_clr", 3'd0, 4'h0, 1'b0, 32'd0, 1'b0);
    step();
    clr = 1'b0;

    // Clear in the cycle Phase2 expires wins over advancing.
    accum = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c <= k; c++) begin
        push("clr_race", 3'(4 + k), 4'(1 << k), 1'((k == 0) && (c == 0)), 32'(c), 1'b0);
        step();
        accum = 1'b0;
      end
    end
    clr = 1'b1;
    push("clr_vs_adv", 3'd0, 4'h0, 1'b0, 32'd0, 1'b0);
    step();
    clr = 1'b0;
    push("no_p3", 3'd0, 4'h0, 1'b0, 32'd0, 1'b0);
    step();

    // Accumulated trigger beats a dropped interrupt in Timeout.
    tmo_cyc = 32'd100;
    tmo_en  = 1'b1;
    push("race_tmo0", 3'd1, 4'h0, 1'b0, 32'd0, 1'b0);
    step();
    push("race_tmo1", 3'd1, 4'h0, 1'b0, 32'd1, 1'b0);
    step();
    accum  = 1'b1;
    tmo_en = 1'b0;
    push("accum_vs_drop", 3'd4, 4'h1, 1'b1, 32'd0, 1'b0);
    step();
    accum = 1'b0;
    clr   = 1'b1;
    push("race_clr", 3'd0, 4'h0, 1'b0, 32'd0, 1'b0);
    step();
    clr = 1'b0;

    // All signals mapped to Phase2, only signals 0 and 2 enabled.
    esc_map = 8'b10_10_10_10;
    esc_en  = 4'b0101;
    accum   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c <= k; c++) begin
        push("map", 3'(4 + k), (k == 2) ? 4'b0101 : 4'b0000,
             1'((k == 0) && (c == 0)), 32'(c), 1'b0);
        step();
        accum = 1'b0;
      end
    end
    push("map_term", 3'd3, 4'h0, 1'b0, 32'd0, 1'b0);
    step();
    clr = 1'b1;
    push("map_clr", 3'd0, 4'h0, 1'b0, 32'd0, 1'b0);
    step();
    clr     = 1'b0;
    esc_map = 8'b11_10_01_00;
    esc_en  = 4'hF;

    // Asynchronous reset in the middle of Phase0.
    phase_cyc = {32'd3, 32'd2, 32'd1, 32'd10};
    accum     = 1'b1;
    push("rst_p0a", 3'd4, 4'h1, 1'b1, 32'd0, 1'b0);
    step();
    accum = 1'b0;
    push("rst_p0b", 3'd4, 4'h1, 1'b0, 32'd1, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    push("async_rst", 3'd0, 4'h0, 1'b0, 32'd0, 1'b0);
    pop_cmp();
    #1;
    rst_n = 1'b1;
    push("post_rst_idle", 3'd0, 4'h0, 1'b0, 32'd0, 1'b0);
    step();

    // Illegal encoding injected into the state register.
    @(negedge clk);
    force dut.state_q = caliptra_esc_phase_ctrl_pkg::state_e'(3'd2);
    #1;
    release dut.state_q;
    push("fault", 3'd3, 4'hF, 1'b0, 32'd0, 1'b1);
    step();
    clr = 1'b1;
    push("fault_clr", 3'd3, 4'hF, 1'b0, 32'd0, 1'b1);
    step();
    push("fault_clr_hold", 3'd3, 4'hF, 1'b0, 32'd0, 1'b1);
    step();
    clr   = 1'b0;
    rst_n = 1'b0;
    #1;
    push("fault_rst", 3'd0, 4'h0, 1'b0, 32'd0, 1'b0);
    pop_cmp();
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/caliptra_esc_phase_ctrl.md
Name: caliptra_esc_phase_ctrl

Overview:
Escalation phase sequencer for the escalation sender/receiver signalling pairs (esc_tx_t/esc_rx_t).
- Starts on an accumulated-alert trigger, or after an interrupt-timeout countdown expires.
- Walks four programmable-length phases, then enters a sticky terminal state.
- Drives per-signal escalation requests into the escalation senders, according to a per-signal phase map.

Parameters:
NumSignals, 4, number of escalation signals (one per sender)
CntW, 32, width of the cycle counter and of all duration inputs

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
en_i  input  1  class enable; gates starting a sequence from Idle and Timeout
clr_i  input  1  clear request; returns to Idle unless locked
clr_lock_i  input  1  when 1, clr_i is ignored in phases and in Terminal
accum_trig_i  input  1  accumulation threshold hit; immediate escalation
timeout_en_i  input  1  interrupt pending; runs the timeout countdown while high
timeout_cyc_i  input  CntW  timeout duration in cycles
phase_cyc_i  input  4*CntW  duration of phase k, in slice [k*CntW +: CntW]
esc_map_i  input  2*NumSignals  phase index assigned to signal i, in slice [2i +: 2]
esc_en_i  input  NumSignals  per-signal escalation enable
esc_sig_req_o  output  NumSignals  registered escalation request to each sender
esc_trig_o  output  1  one-cycle pulse on entry to Phase0
esc_cnt_o  output  CntW  current counter value
esc_state_o  output  3  Idle=0, Timeout=1, Terminal=3, Phase0..3=4..7
esc_fsm_err_o  output  1  sticky; state register held an illegal encoding (2 or 3'bxx?)

Behaviour:
- Async reset: state=Idle, counter=0, esc_sig_req_o=0, esc_trig_o=0, esc_fsm_err_o=0.
- Counter: cleared on every state change; otherwise increments by 1 each cycle in Timeout and Phase0..3; saturates at all-ones, no wrap.
- Idle:
  - en_i & accum_trig_i -> Phase0, esc_trig_o=1 next cycle.
  - else en_i & timeout_en_i -> Timeout.
- Timeout (priority order):
  - accum_trig_i, or counter >= timeout_cyc_i -> Phase0, pulse esc_trig_o.
  - else clr_i, or !en_i, or !timeout_en_i -> Idle.
  - else count.
  - timeout_cyc_i=0: Phase0 follows one cycle after entering Timeout.
- Phase k:
  - clr_i & !clr_lock_i -> Idle. Clear has priority over advance.
  - else counter >= phase_cyc_i[k] -> Phase k+1 (Phase3 -> Terminal).
  - else count.
  - Phase k lasts phase_cyc_i[k]+1 cycles.
  - en_i, accum_trig_i and timeout_en_i are ignored once in a phase.
- Terminal: counter held at 0; leaves only on clr_i & !clr_lock_i -> Idle.
- Illegal state encoding (2 or any unused code):
  - Next state = Terminal.
  - esc_fsm_err_o set; sticky until reset.
  - All esc_sig_req_o forced to 1 while esc_fsm_err_o=1.
- esc_sig_req_o:
  - Flopped from the next-state value.
  - esc_sig_req_o[i]=1 exactly in the cycles where esc_state_o == 4+esc_map_i[i] and esc_en_i[i]=1.
  - Glitch-free; deasserts in the same cycle esc_state_o leaves that phase.
- esc_trig_o: registered, aligned with the first cycle where esc_state_o=Phase0.
- Changes to config inputs take effect in the next comparison; they are not latched.

Test Plan:
- Trigger path: reset; en_i=1, phase_cyc_i={3,2,1,0} for k=0..3, esc_map_i=identity, esc_en_i=4'hF; pulse accum_trig_i.
  - esc_trig_o pulses once.
  - State sequence: Phase0 for 1 cycle, Phase1 for 2, Phase2 for 3, Phase3 for 4, then Terminal.
  - esc_sig_req_o walks 0001, 0010, 0100, 1000, then 0000.
- Timeout path: timeout_en_i held high, timeout_cyc_i=5.
  - Timeout for 6 cycles, esc_cnt_o 0..5, then Phase0.
  - Separate run: drop timeout_en_i at cnt=3 -> Idle, no esc_trig_o.
- Clear and lock:
  - clr_i in Phase1 with clr_lock_i=0 -> Idle the next cycle, requests drop.
  - Same with clr_lock_i=1 -> sequence continues to Terminal; clr_i is ignored there until clr_lock_i=0.
- Simultaneous events:
  - clr_i in the same cycle the Phase2 counter expires -> Idle, Phase3 never seen.
  - accum_trig_i and !timeout_en_i together in Timeout -> Phase0.
- Mapping and enable:
  - esc_map_i all = 2, esc_en_i=4'b0101 -> esc_sig_req_o=0101 only during Phase2.
  - Mid-Phase0 async reset -> all outputs 0 immediately, state Idle.
- Fault injection: force the state register to 2.
  - Next cycle esc_state_o=3 (Terminal), esc_fsm_err_o=1, esc_sig_req_o=4'hF.
  - All three persist through clr_i until reset.
